// File: rtl/bs_link_pkg.sv
// Shared types for the Battleship board-to-board serial link.
// Holds the TX/RX FSM state enums and the frame length helper.
package bs_link_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LEAD,
    TX_DATA,
    TX_PAR,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_LEAD,
    RX_BITS,
    RX_CHECK
  } rx_state_t;

  // Sampled bits per frame: payload plus optional parity.
  function automatic int FRAME_BITS(
    input int width,
    input int parity_en
  );
    return width + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/bs_link_fifo.sv
// First-word fall-through receive FIFO for the serial link.
// Ports: clk, clr_n, push/push_data, pop, head, valid, full.
module bs_link_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             pop_ok;
  logic             push_ok;

  assign valid   = (cnt != '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_ok  = pop & valid;
  // A pop frees the slot a same-cycle push uses.
  assign push_ok = push & (~full | pop_ok);
  assign head    = valid ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop_ok) begin
        rp <= rp + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/bs_link_uart.sv
// Full-duplex framed serial link: TX serialiser, RX deserialiser,
// receive FIFO, error pulses and a game clock-enable.
module bs_link_uart
  import bs_link_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 100,
  parameter int PARITY_EN  = 1,
  parameter int DEPTH      = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_req,
  output logic             tx_busy,
  output logic             tx_line,
  output logic             tx_frame,
  input  logic             rx_line,
  input  logic             rx_frame,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic             rx_overflow,
  output logic             game_ce
);

  localparam int FB = FRAME_BITS(WIDTH, PARITY_EN);
  localparam int CW = $clog2(2 * BIT_CYCLES);
  localparam int IW = $clog2(FB + 1);
  localparam logic [CW-1:0] BIT_END =
    CW'(BIT_CYCLES - 1);
  // First sample lands mid-way through bit 0.
  localparam logic [CW-1:0] LEAD_END =
    CW'(BIT_CYCLES + BIT_CYCLES / 2 - 1);

  tx_state_t        tx_st;
  tx_state_t        tx_nx;
  logic [CW-1:0]    tx_cnt;
  logic [CW-1:0]    tx_cnt_nx;
  logic [IW-1:0]    tx_idx;
  logic [IW-1:0]    tx_idx_nx;
  logic [WIDTH-1:0] tx_sh;
  logic [WIDTH-1:0] tx_sh_nx;
  logic             tx_par;
  logic             tx_par_nx;
  logic             tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_END);
  assign tx_busy    = (tx_st != TX_IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st  <= tx_nx;
      tx_cnt <= tx_cnt_nx;
      tx_idx <= tx_idx_nx;
      tx_sh  <= tx_sh_nx;
      tx_par <= tx_par_nx;
    end
  end

  always_comb begin
    tx_nx     = tx_st;
    tx_cnt_nx = tx_cnt + 1'b1;
    tx_idx_nx = tx_idx;
    tx_sh_nx  = tx_sh;
    tx_par_nx = tx_par;
    tx_line   = 1'b1;
    tx_frame  = 1'b0;
    unique case (tx_st)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (tx_req) begin
          tx_nx     = TX_LEAD;
          tx_sh_nx  = tx_data;
          tx_par_nx = ^tx_data;
        end
      end
      TX_LEAD: begin
        tx_frame = 1'b1;
        if (tx_bit_end) begin
          tx_cnt_nx = '0;
          tx_idx_nx = '0;
          tx_nx     = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_frame = 1'b1;
        tx_line  = tx_sh[0];
        if (tx_bit_end) begin
          tx_cnt_nx = '0;
          tx_sh_nx  = tx_sh >> 1;
          tx_idx_nx = tx_idx + 1'b1;
          if (tx_idx == IW'(WIDTH - 1)) begin
            tx_nx = (PARITY_EN != 0) ? TX_PAR
                                     : TX_GAP;
          end
        end
      end
      TX_PAR: begin
        tx_frame = 1'b1;
        tx_line  = tx_par;
        if (tx_bit_end) begin
          tx_cnt_nx = '0;
          tx_nx     = TX_GAP;
        end
      end
      TX_GAP: begin
        if (tx_bit_end) begin
          tx_cnt_nx = '0;
          tx_nx     = TX_IDLE;
        end
      end
      default: tx_nx = TX_IDLE;
    endcase
  end

  logic [1:0]    line_sync;
  logic [1:0]    frame_sync;
  logic          frame_prev;
  logic          l_s;
  logic          f_s;
  rx_state_t     rx_st;
  rx_state_t     rx_nx;
  logic [CW-1:0] rx_cnt;
  logic [CW-1:0] rx_cnt_nx;
  logic [IW-1:0] rx_n;
  logic [IW-1:0] rx_n_nx;
  logic [FB-1:0] rx_sh;
  logic [FB-1:0] rx_sh_nx;
  logic [FB:0]   rx_shift_in;
  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_pop;

  assign l_s         = line_sync[1];
  assign f_s         = frame_sync[1];
  assign rx_shift_in = {l_s, rx_sh};
  assign fifo_pop    = rx_valid & rx_ready;
  assign game_ce     = (rx_st == RX_IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      line_sync  <= 2'b11;
      frame_sync <= 2'b00;
      frame_prev <= 1'b0;
      rx_st      <= RX_IDLE;
      rx_cnt     <= '0;
      rx_n       <= '0;
      rx_sh      <= '0;
    end else begin
      line_sync  <= {line_sync[0], rx_line};
      frame_sync <= {frame_sync[0], rx_frame};
      frame_prev <= f_s;
      rx_st      <= rx_nx;
      rx_cnt     <= rx_cnt_nx;
      rx_n       <= rx_n_nx;
      rx_sh      <= rx_sh_nx;
    end
  end

  always_comb begin
    rx_nx         = rx_st;
    rx_cnt_nx     = rx_cnt + 1'b1;
    rx_n_nx       = rx_n;
    rx_sh_nx      = rx_sh;
    fifo_push     = 1'b0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    rx_overflow   = 1'b0;
    unique case (rx_st)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (f_s && !frame_prev) begin
          rx_nx   = RX_LEAD;
          rx_n_nx = '0;
        end
      end
      RX_LEAD: begin
        if (!f_s) begin
          rx_nx        = RX_IDLE;
          rx_frame_err = 1'b1;
        end else if (rx_cnt == LEAD_END) begin
          rx_cnt_nx = '0;
          rx_sh_nx  = rx_shift_in[FB:1];
          rx_n_nx   = IW'(1);
          rx_nx     = (FB == 1) ? RX_CHECK
                                : RX_BITS;
        end
      end
      RX_BITS: begin
        if (!f_s) begin
          rx_nx        = RX_IDLE;
          rx_frame_err = 1'b1;
        end else if (rx_cnt == BIT_END) begin
          rx_cnt_nx = '0;
          rx_sh_nx  = rx_shift_in[FB:1];
          rx_n_nx   = rx_n + 1'b1;
          if (rx_n == IW'(FB - 1)) begin
            rx_nx = RX_CHECK;
          end
        end
      end
      RX_CHECK: begin
        rx_nx = RX_IDLE;
        // Even parity: payload plus parity XORs to 0.
        if ((PARITY_EN != 0) && (^rx_sh)) begin
          rx_parity_err = 1'b1;
        end else if (fifo_full && !fifo_pop) begin
          rx_overflow = 1'b1;
        end else begin
          fifo_push = 1'b1;
        end
      end
      default: rx_nx = RX_IDLE;
    endcase
  end

  bs_link_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr_n     (clr_n),
    .push      (fifo_push),
    .push_data (rx_sh[WIDTH-1:0]),
    .pop       (rx_ready),
    .head      (rx_data),
    .valid     (rx_valid),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_bs_link_uart.sv
// Loopback bench for bs_link_uart with a word scoreboard.
// Directed steps: framing, parity, overflow, frame abort, reset.
module tb_bs_link_uart;

  localparam int W  = 16;
  localparam int BC = 8;
  localparam int P  = 1;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [W-1:0] tx_data;
  logic         tx_req;
  logic         tx_busy;
  logic         tx_line;
  logic         tx_frame;
  logic         rx_line;
  logic         rx_frame;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic         rx_parity_err;
  logic         rx_frame_err;
  logic         rx_overflow;
  logic         game_ce;
  logic         corrupt;
  logic         frame_kill;

  always #5 clk = ~clk;

  assign rx_line  = tx_line ^ corrupt;
  assign rx_frame = tx_frame & ~frame_kill;

  bs_link_uart #(
    .WIDTH      (W),
    .BIT_CYCLES (BC),
    .PARITY_EN  (P),
    .DEPTH      (D)
  ) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .tx_data       (tx_data),
    .tx_req        (tx_req),
    .tx_busy       (tx_busy),
    .tx_line       (tx_line),
    .tx_frame      (tx_frame),
    .rx_line       (rx_line),
    .rx_frame      (rx_frame),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overflow   (rx_overflow),
    .game_ce       (game_ce)
  );

  int checks = 0;
  int errors = 0;
  int pe_n = 0;
  int fe_n = 0;
  int of_n = 0;
  logic [W-1:0] sb [$];

  always @(negedge clk) begin
    if (rx_parity_err) pe_n++;
    if (rx_frame_err)  fe_n++;
    if (rx_overflow)   of_n++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sb_pop();
    if (sb.size() == 0) return '1;
    return sb.pop_front();
  endfunction

  // Sends one word and runs a fixed 220-cycle window.
  task automatic xfer(
    input  logic [W-1:0] w,
    input  int           corrupt_at,
    input  int           kill_at,
    input  int           pop_at,
    output int           last_low,
    output int           busy_n,
    output int           low_n,
    output int           falls
  );
    logic prev_ce;
    check("tx idle before send", tx_busy, 1'b0);
    last_low = -1;
    busy_n   = 0;
    low_n    = 0;
    falls    = 0;
    prev_ce  = 1'b1;
    tx_data  = w;
    tx_req   = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    for (int n = 0; n < 220; n++) begin
      if (tx_busy) busy_n++;
      if (!game_ce) begin
        low_n++;
        last_low = n;
      end
      if (prev_ce && !game_ce) falls++;
      prev_ce = game_ce;
      if (n == pop_at) begin
        check("pop-in-check valid", rx_valid, 1'b1);
        check("pop-in-check head", rx_data, sb_pop());
      end
      corrupt    = (n >= corrupt_at) &&
                   (n < corrupt_at + 8);
      frame_kill = (kill_at >= 0) && (n >= kill_at);
      rx_ready   = (n == pop_at);
      @(negedge clk);
    end
    corrupt    = 1'b0;
    frame_kill = 1'b0;
    rx_ready   = 1'b0;
    check("tx idle after window", tx_busy, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    check({tag, " valid"}, rx_valid, 1'b1);
    check({tag, " data"}, rx_data, sb_pop());
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int ll, bn, lw, fl, chk_at;
    int p0, f0, o0;
    clr_n      = 1'b1;
    tx_req     = 1'b0;
    tx_data    = '0;
    rx_ready   = 1'b0;
    corrupt    = 1'b0;
    frame_kill = 1'b0;
    #1 clr_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst tx_line", tx_line, 1'b1);
    check("rst tx_frame", tx_frame, 1'b0);
    check("rst tx_busy", tx_busy, 1'b0);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst rx_data", rx_data, 16'h0);
    check("rst game_ce", game_ce, 1'b1);
    check("rst errs",
          {rx_parity_err, rx_frame_err, rx_overflow},
          3'b000);
    clr_n = 1'b1;
    @(negedge clk);

    // Clean loopback word.
    p0 = pe_n; f0 = fe_n; o0 = of_n;
    sb.push_back(16'hA5C3);
    xfer(16'hA5C3, -100, -1, -1, ll, bn, lw, fl);
    chk_at = ll;
    check("busy cycles", bn, 152);
    check("game_ce low cycles", lw, 12 + 16 * 8 + 1);
    check("game_ce one window", fl, 1);
    check("clean errs",
          (pe_n - p0) + (fe_n - f0) + (of_n - o0), 0);
    pop_check("A5C3");
    check("A5C3 drained", rx_valid, 1'b0);

    // Parity bit inverted on the wire.
    p0 = pe_n;
    xfer(16'h0001, 136, -1, -1, ll, bn, lw, fl);
    check("parity pulse", pe_n - p0, 1);
    check("parity discard", rx_valid, 1'b0);

    // Overflow with a stalled consumer.
    o0 = of_n;
    for (int i = 1; i <= 5; i++) begin
      if (i <= D) sb.push_back(W'(i));
      xfer(W'(i), -100, -1, -1, ll, bn, lw, fl);
      if (i == D) check("no ovf yet", of_n - o0, 0);
    end
    check("ovf once", of_n - o0, 1);
    for (int i = 1; i <= D; i++) pop_check("fifo");
    check("fifo drained", rx_valid, 1'b0);

    // Frame dropped mid-word, then a good word.
    f0 = fe_n; p0 = pe_n;
    xfer(16'h5A5A, -100, 58, -1, ll, bn, lw, fl);
    check("frame err pulse", fe_n - f0, 1);
    check("frame err no parity", pe_n - p0, 0);
    check("frame err discard", rx_valid, 1'b0);
    sb.push_back(16'hBEEF);
    xfer(16'hBEEF, -100, -1, -1, ll, bn, lw, fl);
    pop_check("BEEF");

    // Full FIFO with a pop during the check cycle.
    o0 = of_n;
    for (int i = 10; i < 14; i++) begin
      sb.push_back(W'(i));
      xfer(W'(i), -100, -1, -1, ll, bn, lw, fl);
    end
    sb.push_back(16'd14);
    xfer(16'd14, -100, -1, chk_at, ll, bn, lw, fl);
    check("full+pop no ovf", of_n - o0, 0);
    for (int i = 0; i < D; i++) pop_check("full+pop");
    check("full+pop drained", rx_valid, 1'b0);

    // Async reset mid-transmit and mid-receive.
    xfer(16'h7777, -100, -1, -1, ll, bn, lw, fl);
    tx_data = 16'h5555;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    repeat (80) @(negedge clk);
    check("pre-rst busy", tx_busy, 1'b1);
    check("pre-rst game_ce", game_ce, 1'b0);
    check("pre-rst valid", rx_valid, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    check("arst tx_frame", tx_frame, 1'b0);
    check("arst tx_line", tx_line, 1'b1);
    check("arst tx_busy", tx_busy, 1'b0);
    check("arst rx_valid", rx_valid, 1'b0);
    check("arst game_ce", game_ce, 1'b1);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    p0 = pe_n; f0 = fe_n; o0 = of_n;
    sb.push_back(16'h1234);
    xfer(16'h1234, -100, -1, -1, ll, bn, lw, fl);
    check("post-rst errs",
          (pe_n - p0) + (fe_n - f0) + (of_n - o0), 0);
    pop_check("1234");
    check("post-rst drained", rx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/bs_link_uart.md
Name: bs_link_uart

Overview:
- Parametrised, full-duplex Master/Slave serial link for the Battleship board pair.
- Each direction carries a framed word on two wires: a frame/signal wire and a data bitstream wire.
- Adds over the previous link:
  - configurable word width, bit period and parity;
  - a receive FIFO with valid/ready pop;
  - error reporting;
  - a game clock-enable that stalls game logic while a word is arriving.
- Sits between the board pins and the game top (Master or Slave side, identical instance).

Parameters:
WIDTH, 16, payload bits per word (1..32)
BIT_CYCLES, 100, clk cycles per serial bit (>=4, even)
PARITY_EN, 1, 1 = append even-parity bit after payload; 0 = none
DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, same clock on both boards
clr_n  in  1  asynchronous active-low reset
tx_data  in  WIDTH  word to send, sampled on the accepted tx_req cycle
tx_req  in  1  send request; accepted only when tx_busy=0
tx_busy  out  1  high from the cycle after accept until the trailing idle bit ends
tx_line  out  1  serial data out, LSB first
tx_frame  out  1  frame signal out (peer's rx_frame)
rx_line  in  1  serial data in (asynchronous)
rx_frame  in  1  frame signal in (asynchronous)
rx_data  out  WIDTH  FIFO head word
rx_valid  out  1  FIFO non-empty
rx_ready  in  1  pop head when rx_valid=1
rx_parity_err  out  1  one-cycle pulse; received word failed parity and was discarded
rx_frame_err  out  1  one-cycle pulse; rx_frame fell before the last bit was sampled
rx_overflow  out  1  one-cycle pulse; good word dropped because the FIFO was full
game_ce  out  1  clock-enable for game logic; low while a word is being received

Behaviour:
Reset (clr_n=0, immediate):
- tx_line=1, tx_frame=0, tx_busy=0.
- FIFO empty: rx_valid=0, rx_data=0.
- All error pulses 0; game_ce=1.
- Both FSMs in IDLE.

Transmit FSM (TX_IDLE, TX_LEAD, TX_DATA, TX_PAR, TX_GAP):
- tx_req with tx_busy=0: latch tx_data, go to TX_LEAD next cycle; tx_busy=1 from that edge.
- tx_req while busy: ignored, no queuing.
- TX_LEAD: tx_frame=1, tx_line=1, for BIT_CYCLES.
- TX_DATA: tx_frame=1, tx_line=bit i for BIT_CYCLES each, i=0..WIDTH-1.
- TX_PAR (only if PARITY_EN): tx_line=XOR of payload, BIT_CYCLES.
- TX_GAP: tx_frame=0, tx_line=1, BIT_CYCLES; then TX_IDLE, tx_busy=0.
- Total busy = BIT_CYCLES*(2+WIDTH+PARITY_EN) cycles.
- A new tx_req is accepted on the first cycle tx_busy=0.

Receive FSM (RX_IDLE, RX_LEAD, RX_BITS, RX_CHECK):
- rx_line and rx_frame each pass through a 2-FF synchroniser; all decisions use the synchronised values.
- Rising edge of synced frame in RX_IDLE: enter RX_LEAD; game_ce=0 from that cycle.
- RX_LEAD: wait BIT_CYCLES + BIT_CYCLES/2, then sample bit 0.
- RX_BITS: sample every BIT_CYCLES, WIDTH+PARITY_EN samples total.
- Synced frame low before the final sample: abort to RX_IDLE, pulse rx_frame_err, discard the word.
- RX_CHECK (one cycle), in priority order:
  - parity mismatch → pulse rx_parity_err, discard;
  - FIFO full and no pop this cycle → pulse rx_overflow, discard;
  - else push.
  - Then RX_IDLE; game_ce returns to 1 the cycle after RX_CHECK.
- Frame still high after RX_CHECK: no new word starts until the frame falls and rises again.

FIFO:
- First-word fall-through; rx_data is valid whenever rx_valid=1.
- Pop on rx_valid & rx_ready.
- Push and pop in the same cycle when full: both occur, count unchanged, no overflow.
- Pop when empty: ignored.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Decomposition:
- bs_link_pkg: tx_state_t and rx_state_t enums, plus localparam helper FRAME_BITS(WIDTH,PARITY_EN).
- One sub-module, bs_link_fifo #(WIDTH,DEPTH):
  - ports clk, clr_n, push, push_data, pop, head, valid, full;
  - same reset polarity.
- Synchronisers inline.

Test Plan:
- Loopback (tx→rx), WIDTH=16, BIT_CYCLES=8, PARITY_EN=1, send 16'hA5C3 → tx_busy high exactly 152 cycles; rx_valid=1, rx_data=16'hA5C3, no error pulses; game_ce low for the whole receive window.
- Corrupt parity: force rx_line inverted during the parity bit of 16'h0001 → rx_parity_err single pulse, rx_valid stays 0.
- DEPTH=4, rx_ready=0, send 5 words 1..5 → FIFO holds 1,2,3,4, rx_overflow pulses once on word 5; then pop four times → 1,2,3,4 in order, rx_valid=0.
- Drop rx_frame after 6 of 16 bits → rx_frame_err pulse, FIFO unchanged; next full word 16'hBEEF received correctly.
- Full FIFO with rx_ready=1 held through the RX_CHECK of a new word → word pushed, head popped, no overflow, count stays 4.
- Assert clr_n=0 mid-transmit and mid-receive → tx_frame=0, tx_line=1, tx_busy=0, rx_valid=0, game_ce=1 immediately (asynchronously); post-release send of 16'h1234 succeeds.
